tff_jk_updown_counter: RTL and testbench

- WIDTH-bit synchronous up/down counter. Every bit is a T flip-flop realised from a JK flip-flop core, with J = K = T.
- It is the converse of the JK-from-T conversion. It is the first counter block built on the flip-flop conversion cells.
- It sits in the sequential-circuits library as a reusable counter. Its bench drives it with the same stimulus style as the flip-flop benches.

---
 rtl/tff_jk_updown_counter.sv | 90 +++++++++
 tb/tb_tff_jk_updown_counter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tff_jk_updown_counter.sv
// rtl/tff_jk_updown_counter.sv - WIDTH-bit up/down counter built from JK-based T flip-flop stages
//
// Purpose:
//   Synchronous up/down counter. Each bit is a JK flip-flop wired as a T
//   flip-flop (J = K = T). A parallel load drives J = d[i], K = ~d[i] so every
//   stage settles to d[i] in one edge. Priority per edge: rst > load > en > hold.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous active-high reset (q <= 0, wrap <= 0)
//   en    in   1      count enable
//   up    in   1      direction, 1 = up, 0 = down
//   load  in   1      synchronous parallel load of d
//   d     in   WIDTH  load value
//   q     out  WIDTH  counter state (Q outputs of the JK stages)
//   tc    out  1      terminal count, combinational
//   wrap  out  1      registered one-cycle pulse after a wrap-around

module tff_jk_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  // w_ones[i] / w_zeros[i]: all lower bits q[i-1:0] are ones / zeros.
  // Bit 0 has no lower bits, so both prefixes are trivially true there.
  logic [WIDTH-1:0] w_ones;
  logic [WIDTH-1:0] w_zeros;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_q_next;
  logic             w_all_ones;
  logic             w_all_zeros;

  assign w_ones[0]  = 1'b1;
  assign w_zeros[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_prefix
      assign w_ones[gi]  = w_ones[gi-1]  &  r_q[gi-1];
      assign w_zeros[gi] = w_zeros[gi-1] & ~r_q[gi-1];
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      // Toggle term: propagate carry (up) or borrow (down) from the lower bits.
      assign w_t[gi] = en & (up ? w_ones[gi] : w_zeros[gi]);

      // Load forces the JK pair to set/reset; otherwise J = K = T.
      assign w_j[gi] = load ?  d[gi] : w_t[gi];
      assign w_k[gi] = load ? ~d[gi] : w_t[gi];

      // JK characteristic equation.
      assign w_q_next[gi] = (w_j[gi] & ~r_q[gi]) | (~w_k[gi] & r_q[gi]);
    end
  endgenerate

  assign w_all_ones  = w_ones[WIDTH-1]  & r_q[WIDTH-1];
  assign w_all_zeros = w_zeros[WIDTH-1] & ~r_q[WIDTH-1];

  // Terminal count is masked by load so a load on a terminal value never
  // registers a wrap.
  assign tc = en & ~load & (up ? w_all_ones : w_all_zeros);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= tc;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_tff_jk_updown_counter.sv
// tb/tb_tff_jk_updown_counter.sv - scoreboard bench for tff_jk_updown_counter
module tb_tff_jk_updown_counter;

  localparam int WIDTH = 4;
  localparam int MAX   = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] exp_q_fifo [$];
  logic             exp_w_fifo [$];

  int m_q    = 0;
  bit m_init = 0;

  tff_jk_updown_counter #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .d    (d),
    .q    (q),
    .tc   (tc),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input bit r, input bit e, input bit u, input bit l, input int dv);
    int  nq;
    bit  nw;
    bit  etc;
    @(negedge clk);
    rst  = r;
    en   = e;
    up   = u;
    load = l;
    d    = dv[WIDTH-1:0];
    #1;
    if (m_init) begin
      etc = e && !l && (u ? (m_q == MAX) : (m_q == 0));
      checks++;
      if (tc !== etc) begin
        errors++;
        $display("FAIL tc: got %b expected %b (model q=%0d en=%b up=%b load=%b)", tc, etc, m_q, e, u, l);
      end
    end
    if (r) begin
      nq = 0; nw = 0;
    end else if (l) begin
      nq = dv % (MAX + 1); nw = 0;
    end else if (e) begin
      if (u) begin
        nw = (m_q == MAX);
        nq = (m_q + 1) % (MAX + 1);
      end else begin
        nw = (m_q == 0);
        nq = (m_q + MAX) % (MAX + 1);
      end
    end else begin
      nq = m_q; nw = 0;
    end
    exp_q_fifo.push_back(nq[WIDTH-1:0]);
    exp_w_fifo.push_back(nw);
    m_q = nq;
    if (r) m_init = 1;
    @(posedge clk);
  endtask

  // Monitor: after each active edge, compare the DUT against the oldest
  // expectation pushed by the driver.
  initial begin
    logic [WIDTH-1:0] eq;
    logic             ew;
    forever begin
      @(posedge clk);
      #2;
      $display("t=%0t en=%b up=%b load=%b q=%0d tc=%b wrap=%b", $time, en, up, load, q, tc, wrap);
      if (exp_q_fifo.size() > 0) begin
        eq = exp_q_fifo.pop_front();
        ew = exp_w_fifo.pop_front();
        checks++;
        if (q !== eq) begin
          errors++;
          $display("FAIL q: got %0d expected %0d", q, eq);
        end
        checks++;
        if (wrap !== ew) begin
          errors++;
          $display("FAIL wrap: got %b expected %b (q=%0d)", wrap, ew, q);
        end
      end
    end
  end

  initial begin
    int budget;
    rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; d = '0;

    // Reset then count up through a wrap.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 1, 0, 0);

    // Count down from reset.
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);

    // Load while at terminal count with en asserted.
    step(0, 0, 0, 1, 15);
    step(0, 1, 1, 1, 10);

    // Hold, then count down once.
    step(0, 0, 0, 1, 6);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // Direction change and reset mid-operation.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1),
           ($urandom_range(0, 9) == 0),
           $urandom_range(0, MAX));
    end

    // Drain the scoreboard with a bounded wait.
    budget = 0;
    while (exp_q_fifo.size() > 0 && budget < 10) begin
      @(posedge clk);
      #3;
      budget++;
    end
    checks++;
    if (exp_q_fifo.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q_fifo.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
